// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, tag sentinel and station entry type
package alu_rs_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 6;

  // A tag of all-ones means the operand value is already present
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic                        busy;
    logic [OP_W-1:0]             op;
    logic [1:0][TAG_W-1:0]       tag;
    logic [1:0][XLEN-1:0]        val;
    logic [TAG_W-1:0]            target;
    logic [XLEN-1:0]             pc;
  } rs_entry_t;

  // True when a valid broadcast resolves an operand waiting on tag t
  function automatic logic tag_hit(input logic cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] t);
    return cdb_valid && (cdb_tag != TAG_INVALID) && (t == cdb_tag);
  endfunction
endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, broadcast and issue signals of the ALU station
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic             flush;
  logic             in_valid;
  logic [OP_W-1:0]  in_op;
  logic [TAG_W-1:0] in_tag1;
  logic [TAG_W-1:0] in_tag2;
  logic [XLEN-1:0]  in_val1;
  logic [XLEN-1:0]  in_val2;
  logic [TAG_W-1:0] in_target;
  logic [XLEN-1:0]  in_pc;
  logic             full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [XLEN-1:0]  issue_a;
  logic [XLEN-1:0]  issue_b;
  logic [TAG_W-1:0] issue_target;
  logic [XLEN-1:0]  issue_pc;

  modport master (
    output flush, in_valid, in_op, in_tag1, in_tag2, in_val1, in_val2, in_target, in_pc,
    output cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  full, issue_valid, issue_op, issue_a, issue_b, issue_target, issue_pc
  );

  modport slave (
    input  flush, in_valid, in_op, in_tag1, in_tag2, in_val1, in_val2, in_target, in_pc,
    input  cdb_valid, cdb_tag, cdb_data, issue_ready,
    output full, issue_valid, issue_op, issue_a, issue_b, issue_target, issue_pc
  );
endinterface

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder for station slot selection
module rs_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Isolate the lowest set bit
  assign onehot = req & (~req + N'(1));
  assign any    = |req;

  // Scan from the top so the lowest requesting index is the last write
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - integer ALU reservation station with CDB snoop and issue register
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave bus
);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  rs_entry_t          slot [ENTRIES];
  rs_entry_t          new_entry;
  logic [ENTRIES-1:0] free_vec, rdy_vec, free_oh, rdy_oh;
  logic [IW-1:0]      free_idx_unused, rdy_idx;
  logic               free_any, rdy_any, dispatch, issue_load;

  logic             iss_valid;
  logic [OP_W-1:0]  iss_op;
  logic [XLEN-1:0]  iss_a, iss_b, iss_pc;
  logic [TAG_W-1:0] iss_target;

  // Per-slot free and ready request vectors
  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i] = !slot[i].busy;
      rdy_vec[i]  = slot[i].busy && (slot[i].tag[0] == TAG_INVALID)
                                 && (slot[i].tag[1] == TAG_INVALID);
    end
  end

  rs_pick #(.N(ENTRIES), .IW(IW)) u_free_pick (
    .req(free_vec), .onehot(free_oh), .idx(free_idx_unused), .any(free_any)
  );

  rs_pick #(.N(ENTRIES), .IW(IW)) u_rdy_pick (
    .req(rdy_vec), .onehot(rdy_oh), .idx(rdy_idx), .any(rdy_any)
  );

  assign bus.full   = !free_any;
  assign dispatch   = bus.in_valid && free_any && !bus.flush;
  assign issue_load = !iss_valid || bus.issue_ready;

  // Incoming operation, with operands resolved by a same-cycle broadcast
  always_comb begin
    new_entry        = '0;
    new_entry.busy   = 1'b1;
    new_entry.op     = bus.in_op;
    new_entry.tag[0] = bus.in_tag1;
    new_entry.tag[1] = bus.in_tag2;
    new_entry.val[0] = bus.in_val1;
    new_entry.val[1] = bus.in_val2;
    new_entry.target = bus.in_target;
    new_entry.pc     = bus.in_pc;
    for (int k = 0; k < 2; k++) begin
      if (tag_hit(bus.cdb_valid, bus.cdb_tag, new_entry.tag[k])) begin
        new_entry.tag[k] = TAG_INVALID;
        new_entry.val[k] = bus.cdb_data;
      end
    end
  end

  // Slot storage and issue register; flush outranks everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) slot[i] <= '0;
      iss_valid  <= 1'b0;
      iss_op     <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
      iss_pc     <= '0;
      iss_target <= TAG_INVALID;
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) slot[i].busy <= 1'b0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (slot[i].busy) begin
          for (int k = 0; k < 2; k++) begin
            if (tag_hit(bus.cdb_valid, bus.cdb_tag, slot[i].tag[k])) begin
              slot[i].tag[k] <= TAG_INVALID;
              slot[i].val[k] <= bus.cdb_data;
            end
          end
        end
        if (issue_load && rdy_oh[i]) slot[i].busy <= 1'b0;
        if (dispatch && free_oh[i]) slot[i] <= new_entry;
      end
      if (issue_load) begin
        iss_valid <= rdy_any;
        if (rdy_any) begin
          iss_op     <= slot[rdy_idx].op;
          iss_a      <= slot[rdy_idx].val[0];
          iss_b      <= slot[rdy_idx].val[1];
          iss_target <= slot[rdy_idx].target;
          iss_pc     <= slot[rdy_idx].pc;
        end
      end
    end
  end

  assign bus.issue_valid  = iss_valid;
  assign bus.issue_op     = iss_op;
  assign bus.issue_a      = iss_a;
  assign bus.issue_b      = iss_b;
  assign bus.issue_target = iss_target;
  assign bus.issue_pc     = iss_pc;
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed and randomized self-checking bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 4;
  localparam logic [TAG_W-1:0] INV = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_rs_if bus ();

  alu_rs #(.ENTRIES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state: slot contents and the issue register
  logic             m_busy [N];
  logic [OP_W-1:0]  m_op   [N];
  logic [TAG_W-1:0] m_t    [N][2];
  logic [XLEN-1:0]  m_v    [N][2];
  logic [TAG_W-1:0] m_tgt  [N];
  logic [XLEN-1:0]  m_pc   [N];
  logic             mi_valid;
  logic [OP_W-1:0]  mi_op;
  logic [XLEN-1:0]  mi_a, mi_b, mi_pc;
  logic [TAG_W-1:0] mi_tgt;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0;
    bus.in_tag1 = INV; bus.in_tag2 = INV; bus.in_val1 = '0; bus.in_val2 = '0;
    bus.in_target = '0; bus.in_pc = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = INV; bus.cdb_data = '0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                      input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2, input logic [TAG_W-1:0] tgt);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_tag1 = t1; bus.in_val1 = v1;
    bus.in_tag2 = t2; bus.in_val2 = v2; bus.in_target = tgt; bus.in_pc = 32'h100 + XLEN'(tgt);
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  // Advance the model by one clock using the inputs presented this cycle
  task automatic model_step();
    int fr = -1;
    int rd = -1;
    if (bus.flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      mi_valid = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_busy[i] && fr < 0) fr = i;
      if (m_busy[i] && m_t[i][0] == INV && m_t[i][1] == INV && rd < 0) rd = i;
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        if (m_busy[i] && bus.cdb_valid && bus.cdb_tag != INV && m_t[i][k] == bus.cdb_tag) begin
          m_t[i][k] = INV;
          m_v[i][k] = bus.cdb_data;
        end
    if (!mi_valid || bus.issue_ready) begin
      mi_valid = (rd >= 0);
      if (rd >= 0) begin
        mi_op = m_op[rd]; mi_a = m_v[rd][0]; mi_b = m_v[rd][1];
        mi_tgt = m_tgt[rd]; mi_pc = m_pc[rd]; m_busy[rd] = 1'b0;
      end
    end
    if (bus.in_valid && fr >= 0) begin
      m_busy[fr] = 1'b1; m_op[fr] = bus.in_op; m_tgt[fr] = bus.in_target; m_pc[fr] = bus.in_pc;
      m_t[fr][0] = bus.in_tag1; m_v[fr][0] = bus.in_val1;
      m_t[fr][1] = bus.in_tag2; m_v[fr][1] = bus.in_val2;
      for (int k = 0; k < 2; k++)
        if (bus.cdb_valid && bus.cdb_tag != INV && m_t[fr][k] == bus.cdb_tag) begin
          m_t[fr][k] = INV;
          m_v[fr][k] = bus.cdb_data;
        end
    end
  endtask

  function automatic logic model_full();
    logic f = 1'b1;
    for (int i = 0; i < N; i++) f &= m_busy[i];
    return f;
  endfunction

  initial begin
    idle();
    bus.issue_ready = 1'b1;
    #12;
    rst = 1'b0;
    #5;

    // Reset state
    check("rst_full", XLEN'(bus.full), 0);
    check("rst_valid", XLEN'(bus.issue_valid), 0);
    check("rst_target", XLEN'(bus.issue_target), XLEN'(INV));
    check("rst_op", XLEN'(bus.issue_op), 0);
    check("rst_a", bus.issue_a, 0);
    tick();

    // 1: ready operands issue two cycles after dispatch
    disp(6'd1, INV, 5, INV, 7, 4'd3);
    tick(); idle();
    check("t1_n1_valid", XLEN'(bus.issue_valid), 0);
    tick();
    check("t1_valid", XLEN'(bus.issue_valid), 1);
    check("t1_a", bus.issue_a, 5);
    check("t1_b", bus.issue_b, 7);
    check("t1_target", XLEN'(bus.issue_target), 3);
    check("t1_op", XLEN'(bus.issue_op), 1);
    tick();

    // 2: wakeup by broadcast three cycles after dispatch
    disp(6'd2, 4'd2, 0, INV, 1, 4'd5);
    tick(); idle();
    for (int c = 0; c < 2; c++) begin
      check("t2_wait_valid", XLEN'(bus.issue_valid), 0);
      tick();
    end
    cdb(4'd2, 32'h10);
    check("t2_bc_valid", XLEN'(bus.issue_valid), 0);
    tick(); idle();
    check("t2_bc1_valid", XLEN'(bus.issue_valid), 0);
    tick();
    check("t2_valid", XLEN'(bus.issue_valid), 1);
    check("t2_a", bus.issue_a, 32'h10);
    check("t2_b", bus.issue_b, 1);
    tick();

    // 3: broadcast in the dispatch cycle is captured
    disp(6'd3, 4'd4, 0, INV, 2, 4'd6);
    cdb(4'd4, 9);
    tick(); idle();
    tick();
    check("t3_valid", XLEN'(bus.issue_valid), 1);
    check("t3_a", bus.issue_a, 9);
    tick();

    // 4: fill the station, drop a fifth dispatch, free a slot by wakeup
    for (int i = 0; i < 4; i++) begin
      disp(6'd4, 4'(6 + i), 0, INV, 0, 4'(10 + i));
      tick();
    end
    idle();
    check("t4_full", XLEN'(bus.full), 1);
    disp(6'd5, INV, 1, INV, 1, 4'd14);
    tick(); idle();
    check("t4_full_after_drop", XLEN'(bus.full), 1);
    tick();
    check("t4_drop_no_issue", XLEN'(bus.issue_valid), 0);
    cdb(4'd7, 32'h77);
    tick(); idle();
    check("t4_woken_still_full", XLEN'(bus.full), 1);
    tick();
    check("t4_issue_valid", XLEN'(bus.issue_valid), 1);
    check("t4_issue_target", XLEN'(bus.issue_target), 11);
    check("t4_issue_a", bus.issue_a, 32'h77);
    check("t4_full_cleared", XLEN'(bus.full), 0);

    // 6: flush with three busy slots and a held issue
    bus.issue_ready = 1'b0;
    bus.flush = 1'b1;
    tick(); idle();
    bus.issue_ready = 1'b1;
    check("t6_valid", XLEN'(bus.issue_valid), 0);
    check("t6_full", XLEN'(bus.full), 0);
    for (int i = 0; i < 4; i++) begin
      cdb(4'(6 + i), 32'h5);
      tick();
      check("t6_late_cdb", XLEN'(bus.issue_valid), 0);
    end
    idle();
    tick();
    check("t6_quiet", XLEN'(bus.issue_valid), 0);

    // 5: backpressure holds the first op, the second follows the handshake
    bus.issue_ready = 1'b0;
    disp(6'd7, INV, 32'h11, INV, 0, 4'd1);
    tick();
    disp(6'd8, INV, 32'h22, INV, 0, 4'd2);
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      check("t5_hold_valid", XLEN'(bus.issue_valid), 1);
      check("t5_hold_target", XLEN'(bus.issue_target), 1);
      check("t5_hold_a", bus.issue_a, 32'h11);
      if (c < 2) tick();
    end
    bus.issue_ready = 1'b1;
    tick();
    check("t5_second_valid", XLEN'(bus.issue_valid), 1);
    check("t5_second_target", XLEN'(bus.issue_target), 2);
    check("t5_second_a", bus.issue_a, 32'h22);
    tick();

    // Asynchronous reset away from any clock edge
    #2 rst = 1'b1;
    #1;
    check("arst_valid", XLEN'(bus.issue_valid), 0);
    check("arst_target", XLEN'(bus.issue_target), XLEN'(INV));
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    mi_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bus.flush       = ($urandom_range(63) == 0);
      bus.in_valid    = ($urandom_range(9) < 6);
      bus.in_op       = OP_W'($urandom);
      bus.in_tag1     = ($urandom_range(2) == 0) ? INV : TAG_W'($urandom_range(3));
      bus.in_tag2     = ($urandom_range(2) == 0) ? INV : TAG_W'($urandom_range(3));
      bus.in_val1     = $urandom;
      bus.in_val2     = $urandom;
      bus.in_target   = TAG_W'($urandom);
      bus.in_pc       = $urandom;
      bus.cdb_valid   = $urandom_range(1) == 1;
      bus.cdb_tag     = ($urandom_range(7) == 0) ? INV : TAG_W'($urandom_range(3));
      bus.cdb_data    = $urandom;
      bus.issue_ready = ($urandom_range(9) < 7);
      check("rnd_full", XLEN'(bus.full), XLEN'(model_full()));
      check("rnd_valid", XLEN'(bus.issue_valid), XLEN'(mi_valid));
      if (mi_valid) begin
        check("rnd_op", XLEN'(bus.issue_op), XLEN'(mi_op));
        check("rnd_a", bus.issue_a, mi_a);
        check("rnd_b", bus.issue_b, mi_b);
        check("rnd_target", XLEN'(bus.issue_target), XLEN'(mi_tgt));
        check("rnd_pc", bus.issue_pc, mi_pc);
      end
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU unit, sitting directly downstream of the ID/EX latch. It accepts one decoded operation per cycle with per-operand (tag, value) pairs, snoops the writeback/CDB broadcast to resolve pending operands, and issues ready operations one per cycle to the ALU through a valid/ready handshake. Its `full` output drives this unit's `reservation_full` bit back to decode.

## Interface
- `ENTRIES`, default 4: number of station slots, range 2..16.
- `XLEN`, default 32: operand, data and pc width.
- `TAG_W`, default 4: ROB tag width; `TAG_INVALID` is all-ones, meaning "value present".
- `OP_W`, default 6: op-type width.

- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous squash (mispredict); clears the whole station.
- `in_valid` input 1: dispatch request; only asserted when `ex_unit` selects ALU.
- `in_op` input OP_W: operation.
- `in_tag1`, `in_tag2` input TAG_W: operand producer tags.
- `in_val1`, `in_val2` input XLEN: operand values, meaningful when the matching tag is `TAG_INVALID`.
- `in_target` input TAG_W: destination ROB tag.
- `in_pc` input XLEN: instruction pc.
- `full` output 1: all slots busy; combinational from slot state.
- `cdb_valid` input 1: broadcast valid.
- `cdb_tag` input TAG_W: broadcast tag.
- `cdb_data` input XLEN: broadcast value.
- `issue_valid` output 1: the issue register holds an operation.
- `issue_ready` input 1: ALU accepts this cycle.
- `issue_op` output OP_W: operation.
- `issue_a`, `issue_b` output XLEN: operand values.
- `issue_target` output TAG_W: destination tag.
- `issue_pc` output XLEN: pc.

## Operation
- **Slot contents:** busy, op, tag1/val1, tag2/val2, target, pc.
- **Slot ready:** busy and both tags equal `TAG_INVALID`.
- **Dispatch:**
  - Condition: `in_valid && !full && !flush`.
  - Writes the lowest-index free slot.
  - `full` is evaluated on current state only. A slot vacated by issue in the same cycle does not admit dispatch.
  - `in_valid` while `full` is dropped silently. Upstream must stall on `full`.
- **CDB snoop:**
  - When `cdb_valid` is high and `cdb_tag != TAG_INVALID`, every busy slot operand with a matching tag captures `cdb_data` and its tag becomes `TAG_INVALID`.
  - Incoming dispatch operands are also compared against the CDB in the same cycle (bypass), so a tag broadcast during dispatch is never lost.
- **Select:** the lowest-index ready slot is chosen. There is no age fairness.
- **Issue register:**
  - It loads when it is empty, or when `issue_valid && issue_ready`.
  - On load it takes the selected slot and frees that slot (busy=0).
  - If nothing is ready, `issue_valid` clears after a handshake.
  - While `issue_valid && !issue_ready`, the outputs hold stable.
- **Flush:** clears all busy bits and `issue_valid` at the next edge. It has priority over dispatch, CDB capture and issue.
- **Reset values:**
  - `issue_valid`=0, `full`=0, all busy=0.
  - `issue_op`/`issue_a`/`issue_b`/`issue_pc`=0.
  - `issue_target`=`TAG_INVALID`.

## Timing
- **Minimum latency:** dispatch with ready operands in cycle N gives the slot written at edge N. The slot is selected in cycle N+1, and `issue_valid` is high in cycle N+2.
- **CDB wakeup:** a CDB match in cycle N makes the slot ready in N+1, so it issues at the earliest with `issue_valid` in N+2.
- **Throughput:** one dispatch and one issue per cycle.
- **Simultaneous events:**
  - A CDB matching both operands of one slot wakes both.
  - Dispatch and issue in the same cycle are independent.
  - A CDB matching an operand of the slot being selected is irrelevant, since only ready slots are selected.
- **Reset:** `rst` mid-operation clears state immediately, without waiting for a clock edge.

## Structure
- **Shared package:** `XLEN`, `TAG_W`, `OP_W`, `TAG_INVALID`, and the `rs_entry_t` struct (busy, op, tag[2], val[2], target, pc), reused by the other unit stations.
- **Sub-module `rs_pick`:** a parameterised lowest-index priority encoder (request vector in, one-hot plus index plus any-valid out). It is instantiated twice, for free-slot and ready-slot selection.

## Test plan
1. **Ready dispatch:** reset, then dispatch op=ADD, tags `TAG_INVALID`, val1=5, val2=7, target=3. Required: `issue_valid` in cycle N+2 with a=5, b=7, target=3.
2. **CDB wakeup:** dispatch tag1=2, val2=1. Broadcast tag 2, data 0x10 three cycles later. Required: issue a=0x10 two cycles after the broadcast, and no issue before it.
3. **Bypass:** dispatch tag1=4 in the same cycle as CDB tag 4, data 9. Required: issue with a=9.
4. **Full:** dispatch 4 ops with unresolved tags. Required: `full`=1 and a 5th `in_valid` is dropped. After one wakeup and issue, `full`=0 the following cycle.
5. **Backpressure:** two ready ops with `issue_ready`=0 for 3 cycles. Required: the first op's outputs stay stable, and the second issues the cycle after the handshake.
6. **Flush:** 3 busy slots plus `issue_valid`=1, then `flush`. Required: next cycle `issue_valid`=0 and `full`=0, and a late CDB for the old tags causes no issue.
